// File: rtl/draw_point_pkg.sv
// Shared types and constants for the point-plotting framebuffer writer.
// Point struct packs {X, Y, RGB444}; FSM walks IDLE -> CALC -> WRITE.
package draw_point_pkg;

  localparam logic [15:0] cul16HRes  = 16'd320;
  localparam logic [15:0] cul16VRes  = 16'd240;
  localparam int          cRgbWidth  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } teDpsState;

  typedef struct packed {
    logic [8:0]           posX;
    logic [8:0]           posY;
    logic [cRgbWidth-1:0] rgb;
  } tsDpsPoint;

endpackage

// File: rtl/draw_point_fifo.sv
// Single-clock show-ahead FIFO: popData always presents the head entry.
// A push while full is ignored even if a pop happens on the same edge.
module draw_point_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 30
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int            cAw       = $clog2(DEPTH);
  localparam logic [cAw:0]  cFullCount = (cAw + 1)'(DEPTH);

  logic [WIDTH-1:0] memArray [DEPTH];
  logic [cAw-1:0]   wrPtrReg;
  logic [cAw-1:0]   rdPtrReg;
  logic [cAw:0]     countReg;
  logic             doPush;
  logic             doPop;

  assign full    = (countReg == cFullCount);
  assign empty   = (countReg == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = memArray[rdPtrReg];

  always_ff @(posedge clk) begin
    if (doPush) memArray[wrPtrReg] <= pushData;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
      if (doPop)  rdPtrReg <= rdPtrReg + 1'b1;
      if (doPush && !doPop)      countReg <= countReg + 1'b1;
      else if (doPop && !doPush) countReg <= countReg - 1'b1;
    end
  end

endmodule

// File: rtl/draw_point_si.sv
// Buffers incoming points and writes each as one 16-bit framebuffer word.
// Define DRAW_POINT_SI_CLIP_EN to discard and count out-of-frame points.
module draw_point_si
  import draw_point_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          H_RES      = int'(cul16HRes),
  parameter int          V_RES      = int'(cul16VRes),
  parameter logic [16:0] FB_BASE    = 17'd0
) (
  input  logic        csi_fb_clock_clk,
  input  logic        rsi_fb_reset_reset,
  input  logic        coe_dps_ul1Reset_n,
  input  logic        coe_dps_ul1Update,
  input  logic [8:0]  coe_dps_ul9PosX,
  input  logic [8:0]  coe_dps_ul9PosY,
  input  logic [11:0] coe_dps_ul12Rgb12Data,
  output logic [16:0] avm_fb_address,
  output logic        avm_fb_write,
  output logic [15:0] avm_fb_writedata,
  output logic [1:0]  avm_fb_byteenable,
  input  logic        avm_fb_waitrequest,
  output logic [15:0] coe_dps_ul16OverflowCount,
  output logic [15:0] coe_dps_ul16ClipCount,
  output logic        coe_dps_ul1Busy
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || H_RES < 1 || V_RES < 1)
  begin : gBadConfig
    $error("draw_point_si: invalid parameter set");
  end

  localparam logic [31:0] cHRes32 = 32'(H_RES);

  logic        srst;
  tsDpsPoint   pushPoint;
  tsDpsPoint   headPoint;
  tsDpsPoint   holdReg;
  logic        fifoFull;
  logic        fifoEmpty;
  logic        fifoPop;
  logic        clipHit;
  logic [16:0] addrCalc;
  teDpsState   stateReg;
  teDpsState   stateNext;
  logic [16:0] addrReg;
  logic [15:0] dataReg;
  logic [15:0] overflowCountReg;

  // Either reset source clears everything on the same edge.
  assign srst      = rsi_fb_reset_reset | ~coe_dps_ul1Reset_n;
  assign pushPoint = {coe_dps_ul9PosX, coe_dps_ul9PosY, coe_dps_ul12Rgb12Data};
  assign addrCalc  = 17'(32'(FB_BASE) + 32'(holdReg.posY) * cHRes32 + 32'(holdReg.posX));

  draw_point_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(tsDpsPoint))
  ) uFifo (
    .clk      (csi_fb_clock_clk),
    .srst     (srst),
    .push     (coe_dps_ul1Update),
    .pushData (pushPoint),
    .pop      (fifoPop),
    .popData  (headPoint),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

`ifdef DRAW_POINT_SI_CLIP_EN
  localparam logic [31:0] cVRes32 = 32'(V_RES);
  logic [15:0] clipCountReg;

  assign clipHit = (32'(holdReg.posX) >= cHRes32) || (32'(holdReg.posY) >= cVRes32);

  always_ff @(posedge csi_fb_clock_clk) begin
    if (srst) clipCountReg <= '0;
    else if (stateReg == CALC && clipHit && clipCountReg != 16'hFFFF)
      clipCountReg <= clipCountReg + 1'b1;
  end

  assign coe_dps_ul16ClipCount = clipCountReg;
`else
  assign clipHit               = 1'b0;
  assign coe_dps_ul16ClipCount = 16'h0000;
`endif

  // A clipped point retires exactly like an accepted write.
  always_comb begin
    stateNext = stateReg;
    fifoPop   = 1'b0;
    unique case (stateReg)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          stateNext = CALC;
        end
      end
      CALC: begin
        if (clipHit) begin
          fifoPop   = !fifoEmpty;
          stateNext = fifoEmpty ? IDLE : CALC;
        end else begin
          stateNext = WRITE;
        end
      end
      WRITE: begin
        if (!avm_fb_waitrequest) begin
          fifoPop   = !fifoEmpty;
          stateNext = fifoEmpty ? IDLE : CALC;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge csi_fb_clock_clk) begin
    if (srst) begin
      stateReg         <= IDLE;
      holdReg          <= '0;
      addrReg          <= '0;
      dataReg          <= '0;
      overflowCountReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (fifoPop) holdReg <= headPoint;
      if (stateReg == CALC && !clipHit) begin
        addrReg <= addrCalc;
        dataReg <= {4'h0, holdReg.rgb};
      end
      if (coe_dps_ul1Update && fifoFull && overflowCountReg != 16'hFFFF)
        overflowCountReg <= overflowCountReg + 1'b1;
    end
  end

  assign avm_fb_write              = (stateReg == WRITE);
  assign avm_fb_address            = addrReg;
  assign avm_fb_writedata          = dataReg;
  assign avm_fb_byteenable         = 2'b11;
  assign coe_dps_ul16OverflowCount = overflowCountReg;
  assign coe_dps_ul1Busy           = !fifoEmpty || (stateReg != IDLE);

endmodule
